// File: rtl/muldiv_seq.sv
// Sequential signed multiply (radix-2 Booth) and signed divide (restoring on magnitudes).
// One iteration per cycle for 32 cycles, one sign-fix cycle, then a one-cycle DONE pulse.
module muldiv_seq #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic             hi_write,
   output logic             lo_write,
   output logic [WIDTH-1:0] hi_out,
   output logic [WIDTH-1:0] lo_out
);

   localparam int unsigned CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CALC,
      S_FIX,
      S_DONE,
      S_DZERO
   } state_t;

   state_t             r_state;
   state_t             w_next;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_op;
   logic               r_a_neg;
   logic               r_b_neg;
   logic [WIDTH-1:0]   r_m;
   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;
   logic               r_q;

   logic               w_accept;
   logic [WIDTH-1:0]   w_a_abs;
   logic [WIDTH-1:0]   w_b_abs;
   logic [WIDTH:0]     w_psum;
   logic [WIDTH-1:0]   w_rem_sh;
   logic [WIDTH-1:0]   w_quo_sh;
   logic [WIDTH:0]     w_diff;
   logic [WIDTH-1:0]   w_step_hi;
   logic [WIDTH-1:0]   w_step_lo;
   logic [WIDTH-1:0]   w_fix_hi;
   logic [WIDTH-1:0]   w_fix_lo;

   assign w_accept = (r_state == S_IDLE) && start && !(op && (b_in == '0));
   assign w_a_abs  = a_in[WIDTH-1] ? (WIDTH'(0) - a_in) : a_in;
   assign w_b_abs  = b_in[WIDTH-1] ? (WIDTH'(0) - b_in) : b_in;

   // Next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (start) w_next = (op && (b_in == '0)) ? S_DZERO : S_CALC;
         S_CALC:  if (r_cnt == CNT_LAST) w_next = S_FIX;
         S_FIX:   w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         S_DZERO: w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // One iteration: Booth add/sub uses a sign-extended adder so the shifted-in MSB is the true sign
   always_comb begin
      w_psum   = {r_hi[WIDTH-1], r_hi};
      case ({r_lo[0], r_q})
         2'b01:   w_psum = {r_hi[WIDTH-1], r_hi} + {r_m[WIDTH-1], r_m};
         2'b10:   w_psum = {r_hi[WIDTH-1], r_hi} - {r_m[WIDTH-1], r_m};
         default: w_psum = {r_hi[WIDTH-1], r_hi};
      endcase
      w_rem_sh = {r_hi[WIDTH-2:0], r_lo[WIDTH-1]};
      w_quo_sh = {r_lo[WIDTH-2:0], 1'b0};
      w_diff   = {1'b0, w_rem_sh} - {1'b0, r_m};
      if (!r_op) begin
         w_step_hi = w_psum[WIDTH:1];
         w_step_lo = {w_psum[0], r_lo[WIDTH-1:1]};
      end else if (w_diff[WIDTH]) begin
         w_step_hi = w_rem_sh;
         w_step_lo = w_quo_sh;
      end else begin
         w_step_hi = w_diff[WIDTH-1:0];
         w_step_lo = w_quo_sh | WIDTH'(1);
      end
   end

   // Sign fix: quotient negative on sign mismatch, remainder follows the dividend
   always_comb begin
      w_fix_hi = r_hi;
      w_fix_lo = r_lo;
      if (r_op) begin
         if (r_a_neg)           w_fix_hi = WIDTH'(0) - r_hi;
         if (r_a_neg ^ r_b_neg) w_fix_lo = WIDTH'(0) - r_lo;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   // Working registers
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_cnt   <= '0;
         r_op    <= 1'b0;
         r_a_neg <= 1'b0;
         r_b_neg <= 1'b0;
         r_m     <= '0;
         r_hi    <= '0;
         r_lo    <= '0;
         r_q     <= 1'b0;
      end else if (w_accept) begin
         r_cnt   <= '0;
         r_op    <= op;
         r_a_neg <= a_in[WIDTH-1];
         r_b_neg <= b_in[WIDTH-1];
         r_m     <= op ? w_b_abs : a_in;
         r_hi    <= '0;
         r_lo    <= op ? w_a_abs : b_in;
         r_q     <= 1'b0;
      end else if (r_state == S_CALC) begin
         r_cnt   <= r_cnt + 1'b1;
         r_hi    <= w_step_hi;
         r_lo    <= w_step_lo;
         r_q     <= r_lo[0];
      end
   end

   // Output registers; HI/LO only load on the edge entering DONE
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         busy     <= 1'b0;
         done     <= 1'b0;
         div_zero <= 1'b0;
         hi_write <= 1'b0;
         lo_write <= 1'b0;
         hi_out   <= '0;
         lo_out   <= '0;
      end else begin
         busy     <= (w_next != S_IDLE);
         done     <= (w_next == S_DONE);
         div_zero <= (w_next == S_DZERO);
         hi_write <= (w_next == S_DONE);
         lo_write <= (w_next == S_DONE);
         if (r_state == S_FIX) begin
            hi_out <= w_fix_hi;
            lo_out <= w_fix_lo;
         end
      end
   end

endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq: arithmetic reference model checked every cycle plus directed literal results.
module tb_muldiv_seq;

   logic        clock;
   logic        reset;
   logic        start;
   logic        op;
   logic [31:0] a_in;
   logic [31:0] b_in;
   logic        busy;
   logic        done;
   logic        div_zero;
   logic        hi_write;
   logic        lo_write;
   logic [31:0] hi_out;
   logic [31:0] lo_out;

   int n_checks = 0;
   int n_fail   = 0;
   logic chk_en = 1'b0;

   muldiv_seq #(.WIDTH(32)) u_dut (
      .clock(clock), .reset(reset), .start(start), .op(op),
      .a_in(a_in), .b_in(b_in), .busy(busy), .done(done),
      .div_zero(div_zero), .hi_write(hi_write), .lo_write(lo_write),
      .hi_out(hi_out), .lo_out(lo_out)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Result as {hi, lo} from plain signed arithmetic (division truncates toward zero)
   function automatic logic [63:0] model_calc(input logic mop, input logic [31:0] a, input logic [31:0] b);
      longint sa = longint'($signed(a));
      longint sb = longint'($signed(b));
      longint p;
      longint q;
      longint r;
      if (!mop) begin
         p = sa * sb;
         return 64'(p);
      end
      q = sa / sb;
      r = sa % sb;
      return {32'(r), 32'(q)};
   endfunction

   // Model: cycles remaining busy, and the HI/LO values the outputs must hold
   int          m_cnt = 0;
   logic        m_dz  = 1'b0;
   logic [31:0] m_hi  = '0;
   logic [31:0] m_lo  = '0;
   logic [63:0] m_res = '0;

   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         m_cnt <= 0;
         m_dz  <= 1'b0;
         m_hi  <= '0;
         m_lo  <= '0;
      end else if (m_cnt != 0) begin
         m_cnt <= m_cnt - 1;
         if (m_cnt == 2 && !m_dz) begin
            m_hi <= m_res[63:32];
            m_lo <= m_res[31:0];
         end
      end else if (start) begin
         if (op && b_in == 32'd0) begin
            m_cnt <= 1;
            m_dz  <= 1'b1;
         end else begin
            m_cnt <= 34;
            m_dz  <= 1'b0;
            m_res <= model_calc(op, a_in, b_in);
         end
      end
   end

   always @(posedge clock) begin
      #1;
      if (chk_en) begin
         chk("busy",     64'(busy),     64'(m_cnt != 0));
         chk("done",     64'(done),     64'(m_cnt == 1 && !m_dz));
         chk("hi_write", 64'(hi_write), 64'(m_cnt == 1 && !m_dz));
         chk("lo_write", 64'(lo_write), 64'(m_cnt == 1 && !m_dz));
         chk("div_zero", 64'(div_zero), 64'(m_cnt == 1 && m_dz));
         chk("hi_out",   64'(hi_out),   64'(m_hi));
         chk("lo_out",   64'(lo_out),   64'(m_lo));
      end
   end

   // Issue one op in the current (post-negedge) cycle and track it to completion
   task automatic run_op(input logic o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                         input logic dz, input logic restart);
      int  done_c = -1;
      int  dz_c   = -1;
      int  busy_n = 0;
      logic fin   = 1'b0;
      logic poked = 1'b0;
      start = 1'b1; op = o; a_in = a; b_in = b;
      for (int c = 0; c < 60 && !fin; c++) begin
         @(posedge clock); #1;
         if (busy) busy_n++;
         if (done && done_c < 0) done_c = c;
         if (div_zero && dz_c < 0) dz_c = c;
         if (!busy) fin = 1'b1;
         @(negedge clock);
         if (c == 0) begin
            start = 1'b0; op = ~o; a_in = $urandom; b_in = $urandom;
         end
         if (restart && c == 4) begin
            start = 1'b1; op = 1'b0; a_in = 32'h0001_2345; b_in = 32'h3;
         end
         if (restart && c == 5) start = 1'b0;
         if (poked) begin
            start = 1'b0; poked = 1'b0;
         end else if (done || div_zero) begin
            start = 1'b1; op = 1'b0; a_in = 32'd2; b_in = 32'd3; poked = 1'b1;
         end
      end
      start = 1'b0;
      chk("op_finished", 64'(fin), 64'd1);
      if (dz) begin
         chk("dz_cycle",   64'(dz_c),   64'(0));
         chk("dz_nodone",  64'(done_c), 64'(-1));
         chk("dz_busy_n",  64'(busy_n), 64'(1));
      end else begin
         chk("done_cycle", 64'(done_c), 64'(33));
         chk("busy_n",     64'(busy_n), 64'(34));
         chk("no_dz",      64'(dz_c),   64'(-1));
      end
      chk("result_hi", 64'(hi_out), 64'(exp_hi));
      chk("result_lo", 64'(lo_out), 64'(exp_lo));
   endtask

   initial begin
      logic saw_done;
      reset = 1'b1; start = 1'b0; op = 1'b0; a_in = '0; b_in = '0;
      #3 reset = 1'b0;
      chk_en = 1'b1;
      #20;
      chk("rst_busy",  64'(busy),  64'd0);
      chk("rst_hi_lo", {hi_out, lo_out}, 64'd0);
      chk("rst_flags", 64'({done, div_zero, hi_write, lo_write}), 64'd0);

      // Start on the same cycle reset releases; second start mid-op ignored
      @(negedge clock); reset = 1'b1;
      run_op(1'b0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 1'b1);
      @(negedge clock); run_op(1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b0, 1'b0);
      @(negedge clock); run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0);
      @(negedge clock); run_op(1'b1, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0, 1'b0);
      @(negedge clock); run_op(1'b1, 32'd5, 32'd0, 32'd1, 32'hFFFF_FFFD, 1'b1, 1'b0);
      @(negedge clock); run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 1'b0);
      @(negedge clock); run_op(1'b1, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1'b0);
      @(negedge clock); run_op(1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd14, 1'b0, 1'b0);
      @(negedge clock); run_op(1'b1, 32'd5, 32'h8000_0000, 32'd5, 32'd0, 1'b0, 1'b0);
      @(negedge clock); run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd1, 1'b0, 1'b0);
      @(negedge clock); run_op(1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);

      // Abort a multiply with reset at cycle 10
      saw_done = 1'b0;
      @(negedge clock); start = 1'b1; op = 1'b0; a_in = 32'd5; b_in = 32'd6;
      for (int c = 0; c < 10; c++) begin
         @(posedge clock); #1;
         if (done || hi_write || lo_write) saw_done = 1'b1;
         @(negedge clock);
         if (c == 0) start = 1'b0;
         if (c == 4) begin start = 1'b1; a_in = 32'd9; b_in = 32'd9; end
         if (c == 5) start = 1'b0;
      end
      reset = 1'b0;
      #1;
      chk("abort_busy",  64'(busy), 64'd0);
      chk("abort_flags", 64'({done, div_zero, hi_write, lo_write}), 64'd0);
      chk("abort_hi_lo", {hi_out, lo_out}, 64'd0);
      chk("abort_nodone", 64'(saw_done), 64'd0);
      repeat (2) @(negedge clock);
      reset = 1'b1;
      run_op(1'b0, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 1'b0);

      repeat (3) @(posedge clock);
      #2;
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
